// File: rtl/instr_issue_if.sv
// Instruction issue bus: upstream word handshake plus controller start/waiting
// and decoded instruction fields.
interface instr_issue_if;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic        waiting;
    logic [1:0]  reg_sel;
    logic        start;
    logic [2:0]  opcode;
    logic [1:0]  ALU_op;
    logic [1:0]  shift_op;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
    logic [2:0]  r_addr;
    logic        illegal;

    modport master (
        output in_valid, in_instr, waiting, reg_sel,
        input  in_ready, start, opcode, ALU_op, shift_op,
        input  sximm8, sximm5, r_addr, illegal
    );

    modport slave (
        input  in_valid, in_instr, waiting, reg_sel,
        output in_ready, start, opcode, ALU_op, shift_op,
        output sximm8, sximm5, r_addr, illegal
    );
endinterface

// File: rtl/instr_issue.sv
// instr_issue: 4-deep instruction FIFO feeding a start/waiting issue FSM.
// Define INSTR_ILLEGAL_TRAP_EN to halt on a bad opcode with a sticky illegal flag.
module instr_issue (
    input  logic          clk,
    input  logic          rst_n,
    instr_issue_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [15:0] mem [4];
    logic [1:0]  wp;
    logic [1:0]  rp;
    logic [2:0]  count;
    logic [15:0] ir;
    logic [15:0] head;
    logic        head_legal;
    logic        push;
    logic        pop;
    logic        load;
    logic        discard;
    logic        can_pop;
    logic        halt;
    logic        start_q;
    logic        start_d;

    assign head       = mem[rp];
    assign head_legal = (head[15:13] == 3'b101) || (head[15:13] == 3'b110);

    // Readiness comes from the registered count so a same-cycle pop never frees a slot.
    assign bus.in_ready = (count < 3'd4);
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = load || discard;
    assign can_pop      = (count != 3'd0) && bus.waiting && !halt;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= bus.in_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wp    <= 2'd0;
            rp    <= 2'd0;
            count <= 3'd0;
        end else begin
            if (push) begin
                wp <= wp + 2'd1;
            end
            if (pop) begin
                rp <= rp + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef INSTR_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            illegal_q <= 1'b0;
        end else if (discard) begin
            illegal_q <= 1'b1;
        end
    end

    assign halt        = illegal_q;
    assign bus.illegal = illegal_q;
`else
    assign halt        = 1'b0;
    assign bus.illegal = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state   <= IDLE;
            start_q <= 1'b0;
        end else begin
            state   <= state_nx;
            start_q <= start_d;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (can_pop && head_legal) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (!bus.waiting) begin
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (bus.waiting) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // start is held while the controller still reports idle; it drops on the
    // same edge that moves ISSUE to BUSY.
    always_comb begin
        load    = 1'b0;
        discard = 1'b0;
        start_d = 1'b0;
        unique case (state)
            IDLE: begin
                load    = can_pop && head_legal;
                discard = can_pop && !head_legal;
            end
            ISSUE: begin
                start_d = bus.waiting;
            end
            default: begin
                start_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            ir <= 16'h0000;
        end else if (load) begin
            ir <= head;
        end
    end

    assign bus.start    = start_q;
    assign bus.opcode   = ir[15:13];
    assign bus.ALU_op   = ir[12:11];
    assign bus.shift_op = ir[4:3];
    assign bus.sximm8   = {{8{ir[7]}}, ir[7:0]};
    assign bus.sximm5   = {{11{ir[4]}}, ir[4:0]};

    always_comb begin
        bus.r_addr = 3'b000;
        unique case (bus.reg_sel)
            2'b10:   bus.r_addr = ir[10:8];
            2'b01:   bus.r_addr = ir[7:5];
            2'b00:   bus.r_addr = ir[2:0];
            default: bus.r_addr = 3'b000;
        endcase
    end
endmodule

// File: tb/tb_instr_issue.sv
// Directed bench for instr_issue: issued words are queued on push and
// checked against the decoded outputs when start rises.
module tb_instr_issue;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [15:0] exp_q[$];

    instr_issue_if bus();

    instr_issue dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(logic [15:0] w);
        bus.in_valid = 1'b1;
        bus.in_instr = w;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_issue(string tag);
        int n;
        logic [15:0] w;
        n = 0;
        while (bus.start !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk({tag, "_start"}, bus.start, 1);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
        end else begin
            w = exp_q.pop_front();
            chk({tag, "_opcode"}, bus.opcode, w[15:13]);
            chk({tag, "_alu"}, bus.ALU_op, w[12:11]);
            chk({tag, "_shift"}, bus.shift_op, w[4:3]);
            chk({tag, "_sx8"}, bus.sximm8, {{8{w[7]}}, w[7:0]});
            chk({tag, "_sx5"}, bus.sximm5, {{11{w[4]}}, w[4:0]});
            bus.reg_sel = 2'b10;
            #1;
            chk({tag, "_rn"}, bus.r_addr, w[10:8]);
            bus.reg_sel = 2'b00;
            #1;
            chk({tag, "_rm"}, bus.r_addr, w[2:0]);
            bus.reg_sel = 2'b10;
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_instr = 16'h0000;
        bus.waiting  = 1'b1;
        bus.reg_sel  = 2'b10;

        tick();
        tick();
        rst_n = 1'b0;
        chk("rst_start", bus.start, 0);
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_opcode", bus.opcode, 0);
        chk("rst_sx8", bus.sximm8, 0);
        chk("rst_sx5", bus.sximm5, 0);
        chk("rst_illegal", bus.illegal, 0);
        chk("rst_count", dut.count, 0);

        // MOV R2,#5: IR at N+1, start after N+2
        exp_q.push_back(16'hD205);
        push_word(16'hD205);
        chk("lat_n0_start", bus.start, 0);
        tick();
        chk("lat_n1_start", bus.start, 0);
        chk("lat_n1_opcode", bus.opcode, 3'b110);
        tick();
        chk("lat_n2_start", bus.start, 1);
        chk("mov_sx8", bus.sximm8, 16'h0005);
        chk("mov_alu", bus.ALU_op, 2'b10);
        chk("mov_rn", bus.r_addr, 3'd2);
        wait_issue("mov");

        exp_q.push_back(16'hA9F7);
        push_word(16'hA9F7);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_start", bus.start, 1);
            chk("hold_ir", dut.ir, 16'hD205);
        end
        bus.waiting = 1'b0;
        tick();
        chk("busy_start0", bus.start, 0);
        tick();
        chk("busy_start1", bus.start, 0);
        chk("busy_ir", dut.ir, 16'hD205);
        bus.waiting = 1'b1;
        wait_issue("next");
        bus.reg_sel = 2'b11;
        #1;
        chk("rsel11", bus.r_addr, 0);
        bus.reg_sel = 2'b01;
        #1;
        chk("rsel01", bus.r_addr, 3'd7);
        bus.reg_sel = 2'b10;

        // fill with the controller busy
        bus.waiting = 1'b0;
        tick();
        chk("fill_busy", bus.start, 0);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_instr = 16'hA001 + 16'(i);
            chk("fill_ready", bus.in_ready, (i < 4) ? 1 : 0);
            if (i < 4) exp_q.push_back(bus.in_instr);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("full_count", dut.count, 4);
        chk("full_ready", bus.in_ready, 0);
        tick();
        tick();
        chk("full_hold", dut.count, 4);

        // pop on a full FIFO must not admit a push that same cycle
        bus.waiting = 1'b1;
        tick();
        bus.in_valid = 1'b1;
        bus.in_instr = 16'hA006;
        chk("popfull_ready", bus.in_ready, 0);
        tick();
        chk("popfull_count", dut.count, 3);
        chk("popfull_ready1", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        exp_q.push_back(16'hA006);
        chk("refill_count", dut.count, 4);
        wait_issue("a001");

        bus.waiting = 1'b0;
        tick();
        bus.waiting = 1'b1;
        wait_issue("a002");

        // reset in BUSY with three entries queued
        bus.waiting = 1'b0;
        tick();
        chk("pre_rst_count", dut.count, 3);
        chk("pre_rst_start", bus.start, 0);
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        exp_q.delete();
        chk("mid_rst_count", dut.count, 0);
        chk("mid_rst_start", bus.start, 0);
        chk("mid_rst_ready", bus.in_ready, 1);
        chk("mid_rst_opcode", bus.opcode, 0);
        bus.waiting = 1'b1;
        tick();
        tick();
        chk("mid_rst_idle", bus.start, 0);

        // illegal opcode 111 followed by a legal word
        push_word(16'hE000);
        bus.in_valid = 1'b1;
        bus.in_instr = 16'hD307;
        tick();
        bus.in_valid = 1'b0;
        chk("ill_start0", bus.start, 0);
`ifdef INSTR_ILLEGAL_TRAP_EN
        chk("ill_flag", bus.illegal, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("ill_nostart", bus.start, 0);
        end
        chk("ill_count", dut.count, 1);
        chk("ill_sticky", bus.illegal, 1);
`else
        chk("ill_flag", bus.illegal, 0);
        tick();
        chk("ill_start1", bus.start, 0);
        exp_q.push_back(16'hD307);
        wait_issue("after_ill");
        chk("ill_flag_end", bus.illegal, 0);
`endif
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        chk("end_rst_illegal", bus.illegal, 0);
        chk("end_rst_count", dut.count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_issue.md
INSTR_ISSUE -- requirements
Module: instr_issue

Interface
REQ-001 The block SHALL have the following ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-high reset (asserted = 1), sampled on rising clk.
- in_valid  in  1  upstream instruction word present.
- in_instr  in  16  instruction word.
- in_ready  out  1  block accepts in_instr this cycle.
- waiting  in  1  controller idle indication.
- reg_sel  in  2  controller register-field select.
- start  out  1  issue request to controller.
- opcode  out  3  IR[15:13].
- ALU_op  out  2  IR[12:11].
- shift_op  out  2  IR[4:3].
- sximm8  out  16  IR[7:0] sign-extended.
- sximm5  out  16  IR[4:0] sign-extended.
- r_addr  out  3  register number selected by reg_sel.
- illegal  out  1  sticky illegal-opcode flag (trap build only; 0 otherwise).

Function
REQ-002 The block SHALL buffer instructions in a 4-entry FIFO with 2-bit wrapping read/write pointers and a 3-bit occupancy count (0..4).
REQ-003 in_ready SHALL be 1 iff count < 4; a push SHALL occur iff in_valid && in_ready.
- in_ready SHALL be computed from the registered count only, so a pop in the same cycle does not enable a push when full.
REQ-004 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-005 The issue FSM SHALL have three states: IDLE, ISSUE and BUSY.
REQ-006 IDLE SHALL move to ISSUE when count > 0 and waiting == 1, popping the FIFO head into the 16-bit instruction register (IR) on the same edge.
REQ-007 ISSUE SHALL drive start = 1 and SHALL move to BUSY on the first cycle that samples waiting == 0.
- start SHALL be held high indefinitely until then.
REQ-008 BUSY SHALL drive start = 0 and SHALL move to IDLE on the first cycle that samples waiting == 1.
REQ-009 start SHALL be 0 in IDLE and BUSY; start SHALL be a registered output.
REQ-010 opcode, ALU_op, shift_op, sximm8 and sximm5 SHALL decode combinationally from IR only.
- These outputs SHALL therefore be stable throughout ISSUE and BUSY.
REQ-011 r_addr SHALL be combinational from reg_sel and IR:
- 2'b10 gives IR[10:8] (Rn).
- 2'b01 gives IR[7:5] (Rd).
- 2'b00 gives IR[2:0] (Rm).
- 2'b11 gives 3'b000.
REQ-012 Legal opcodes SHALL be 3'b101 and 3'b110; any other opcode at the FIFO head SHALL be handled per REQ-017/REQ-018 and SHALL NOT raise start.
REQ-013 Minimum latency SHALL be: push at edge N, then with waiting = 1, IR is loaded at edge N+1 and start = 1 is visible after edge N+2.

Reset
REQ-014 When rst_n = 1 at a rising edge, the block SHALL clear the following:
- pointers = 0, count = 0, IR = 16'h0000, FSM = IDLE.
- start = 0, illegal = 0.
- Resulting outputs: in_ready = 1, opcode = 0, sximm8 = 0, sximm5 = 0.
REQ-015 Reset SHALL take priority over push, pop and FSM transitions, including mid-ISSUE or mid-BUSY.
- Buffered instructions SHALL be discarded.
REQ-016 FIFO storage contents SHALL need no reset.

Configuration
REQ-017 With macro INSTR_ILLEGAL_TRAP_EN defined, an illegal opcode popped in IDLE SHALL behave as follows:
- It SHALL set illegal = 1 (sticky until reset).
- The FSM SHALL then remain in IDLE with no further pops or issues.
- Pushes SHALL continue until full.
REQ-018 Without INSTR_ILLEGAL_TRAP_EN, an illegal opcode SHALL be popped and discarded in one cycle while the FSM stays in IDLE.
- illegal SHALL be tied to 0.

Verification
REQ-019 Directed scenarios the bench SHALL cover:
- Reset, then push 16'hD205 (MOV R2,#5) with waiting = 1 -> start = 1 two edges after push; opcode = 110, ALU_op = 10, sximm8 = 16'h0005; reg_sel = 10 gives r_addr = 2.
- Hold waiting = 1 for 5 cycles during ISSUE -> start stays 1 and IR is unchanged; waiting = 0 -> BUSY with start = 0; waiting = 1 -> IDLE, next entry issued.
- Push 5 words back-to-back with waiting = 0 -> in_ready = 0 after the 4th; the 5th is not accepted; count = 4 held.
- Full FIFO with a pop and in_valid = 1 in the same cycle -> no push that cycle; count = 3; push accepted next cycle; count = 4.
- Push 16'hE000 (opcode 111) -> without the macro, discarded with no start and the next word issues; with INSTR_ILLEGAL_TRAP_EN, illegal = 1 and subsequent words are never issued.
- Assert rst_n = 1 during BUSY with 3 entries queued -> next cycle count = 0, start = 0, in_ready = 1, FSM = IDLE.
